// File: rtl/id_ex_ctrl_pipe.sv
// id_ex_ctrl_pipe: MIPS control decode, ID/EX register and MEM/WB delay line.
// Optional load-use interlock enabled by defining HAZARD_INTERLOCK_EN.
module id_ex_ctrl_pipe #(
    parameter int WB_DELAY = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_func,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [2:0]       ex_alu_ctrl,
    output logic             ex_alu_src1,
    output logic             ex_alu_src2,
    output logic             ex_sign_or_zero,
    output logic             ex_branch_eq,
    output logic             ex_branch_neq,
    output logic [1:0]       ex_pcsrc,
    output logic [4:0]       ex_wreg,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             wb_valid,
    output logic             wb_regwrite,
    output logic             wb_mem2reg,
    output logic [4:0]       wb_wreg,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef struct packed {
        logic       v;
        logic       mr;
        logic       mw;
        logic       rw;
        logic       m2r;
        logic [4:0] wr;
    } dl_t;

    logic [2:0] w_alu;
    logic       w_s1, w_s2, w_sz, w_beq, w_bne;
    logic [1:0] w_pc;
    logic       w_mr, w_mw, w_rw, w_m2r;
    logic       w_rtype, w_jal, w_known, w_uses_rt;
    logic [4:0] w_dst;
    logic       w_rw_eff;
    logic       w_take;

    logic [2:0] r_ex_alu;
    logic       r_ex_valid, r_ex_s1, r_ex_s2, r_ex_sz, r_ex_beq, r_ex_bne;
    logic [1:0] r_ex_pc;
    logic [4:0] r_ex_wreg;
    logic       r_ex_mr, r_ex_mw, r_ex_rw, r_ex_m2r;

    dl_t              r_dl [WB_DELAY];
    logic [CNT_W-1:0] r_cnt;

    // Opcode/func decode into the raw control bundle; unknown encodings stay zero
    always_comb begin
        w_alu     = 3'b000;
        w_s1      = 1'b0;
        w_s2      = 1'b0;
        w_sz      = 1'b0;
        w_beq     = 1'b0;
        w_bne     = 1'b0;
        w_pc      = 2'd0;
        w_mr      = 1'b0;
        w_mw      = 1'b0;
        w_rw      = 1'b0;
        w_m2r     = 1'b0;
        w_rtype   = 1'b0;
        w_jal     = 1'b0;
        w_known   = 1'b0;
        w_uses_rt = 1'b0;
        unique case (id_opcode)
            6'h00: begin
                w_rtype   = 1'b1;
                w_uses_rt = 1'b1;
                unique case (id_func)
                    6'h20: begin w_known = 1'b1; w_rw = 1'b1; w_alu = 3'b000; end
                    6'h22: begin w_known = 1'b1; w_rw = 1'b1; w_alu = 3'b001; end
                    6'h24: begin w_known = 1'b1; w_rw = 1'b1; w_alu = 3'b010; end
                    6'h25: begin w_known = 1'b1; w_rw = 1'b1; w_alu = 3'b011; end
                    6'h2a: begin w_known = 1'b1; w_rw = 1'b1; w_alu = 3'b111; end
                    6'h02: begin
                        w_known = 1'b1;
                        w_rw    = 1'b1;
                        w_alu   = 3'b101;
                        w_s1    = 1'b1;
                    end
                    6'h08: begin w_known = 1'b1; w_pc = 2'd3; end
                    default: ;
                endcase
            end
            6'h08: begin w_known = 1'b1; w_s2 = 1'b1; w_rw = 1'b1; end
            6'h0c: begin
                w_known = 1'b1; w_alu = 3'b010;
                w_s2 = 1'b1; w_sz = 1'b1; w_rw = 1'b1;
            end
            6'h0d: begin
                w_known = 1'b1; w_alu = 3'b011;
                w_s2 = 1'b1; w_sz = 1'b1; w_rw = 1'b1;
            end
            6'h23: begin
                w_known = 1'b1; w_s2 = 1'b1;
                w_mr = 1'b1; w_rw = 1'b1; w_m2r = 1'b1;
            end
            6'h0f: begin w_known = 1'b1; w_alu = 3'b110; w_s2 = 1'b1; w_rw = 1'b1; end
            6'h2b: begin w_known = 1'b1; w_s2 = 1'b1; w_mw = 1'b1; w_uses_rt = 1'b1; end
            6'h0a: begin w_known = 1'b1; w_alu = 3'b111; w_s2 = 1'b1; w_rw = 1'b1; end
            6'h04: begin w_known = 1'b1; w_alu = 3'b001; w_beq = 1'b1; w_uses_rt = 1'b1; end
            6'h05: begin w_known = 1'b1; w_alu = 3'b001; w_bne = 1'b1; w_uses_rt = 1'b1; end
            6'h02: begin w_known = 1'b1; w_pc = 2'd2; end
            6'h03: begin w_known = 1'b1; w_pc = 2'd2; w_rw = 1'b1; w_jal = 1'b1; end
            default: ;
        endcase
    end

    // Destination select; writes to $0 are suppressed
    assign w_dst    = !w_known ? 5'd0 : w_jal ? 5'd31 : w_rtype ? id_rd : id_rt;
    assign w_rw_eff = w_rw & (w_dst != 5'd0);

`ifdef HAZARD_INTERLOCK_EN
    logic w_hit;
    assign w_hit = (r_ex_wreg == id_rs) | (w_uses_rt & (r_ex_wreg == id_rt));
    assign stall = reset & id_valid & r_ex_valid & r_ex_mr & r_ex_rw & w_hit & ~flush;
`else
    logic w_unused_hz;
    assign w_unused_hz = ^{id_rs, w_uses_rt};
    assign stall = 1'b0;
`endif

    assign w_take = id_valid & ~flush & ~stall;

    // ID/EX register: load decoded bundle or insert a bubble
    always_ff @(posedge clk) begin
        if (!reset || !w_take) begin
            r_ex_valid <= 1'b0;
            r_ex_alu   <= 3'b000;
            r_ex_s1    <= 1'b0;
            r_ex_s2    <= 1'b0;
            r_ex_sz    <= 1'b0;
            r_ex_beq   <= 1'b0;
            r_ex_bne   <= 1'b0;
            r_ex_pc    <= 2'd0;
            r_ex_wreg  <= 5'd0;
            r_ex_mr    <= 1'b0;
            r_ex_mw    <= 1'b0;
            r_ex_rw    <= 1'b0;
            r_ex_m2r   <= 1'b0;
        end else begin
            r_ex_valid <= 1'b1;
            r_ex_alu   <= w_alu;
            r_ex_s1    <= w_s1;
            r_ex_s2    <= w_s2;
            r_ex_sz    <= w_sz;
            r_ex_beq   <= w_beq;
            r_ex_bne   <= w_bne;
            r_ex_pc    <= w_pc;
            r_ex_wreg  <= w_dst;
            r_ex_mr    <= w_mr;
            r_ex_mw    <= w_mw;
            r_ex_rw    <= w_rw_eff;
            r_ex_m2r   <= w_m2r;
        end
    end

    // MEM..WB delay line, advances every cycle regardless of stall
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < WB_DELAY; i++) r_dl[i] <= '0;
        end else begin
            r_dl[0] <= '{v: r_ex_valid, mr: r_ex_mr, mw: r_ex_mw,
                         rw: r_ex_rw, m2r: r_ex_m2r, wr: r_ex_wreg};
            for (int i = 1; i < WB_DELAY; i++) r_dl[i] <= r_dl[i-1];
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!reset) r_cnt <= '0;
        else if (r_dl[WB_DELAY-1].v) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign ex_valid        = r_ex_valid;
    assign ex_alu_ctrl     = r_ex_alu;
    assign ex_alu_src1     = r_ex_s1;
    assign ex_alu_src2     = r_ex_s2;
    assign ex_sign_or_zero = r_ex_sz;
    assign ex_branch_eq    = r_ex_beq;
    assign ex_branch_neq   = r_ex_bne;
    assign ex_pcsrc        = r_ex_pc;
    assign ex_wreg         = r_ex_wreg;
    assign mem_memread     = r_dl[0].mr;
    assign mem_memwrite    = r_dl[0].mw;
    assign wb_valid        = r_dl[WB_DELAY-1].v;
    assign wb_regwrite     = r_dl[WB_DELAY-1].rw;
    assign wb_mem2reg      = r_dl[WB_DELAY-1].m2r;
    assign wb_wreg         = r_dl[WB_DELAY-1].wr;
    assign retire_cnt      = r_cnt;

endmodule
